// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// FSM states and datapath mux/function select codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH = 4'd0,
        S_DCD   = 4'd1,
        S_MA    = 4'd2,
        S_MR    = 4'd3,
        S_MW    = 4'd4,
        S_WBM   = 4'd5,
        S_EXE   = 4'd6,
        S_WBA   = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9,
        S_ILL   = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_DM  = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction class decoder feeding the DCD-state transitions.
module mc_ctrl_dec
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       is_rtype,
    output logic       is_imm,
    output logic       is_mem,
    output logic       is_br,
    output logic       is_jmp,
    output logic       is_illegal
);

    logic is_jr;

    always_comb begin
        is_jr      = (op == OP_RTYPE) && (funct == FN_JR);
        // is_rtype covers only the ALU R-types; jr is grouped with the jumps
        is_rtype   = (op == OP_RTYPE) && ((funct == FN_ADDU) || (funct == FN_SUBU));
        is_imm     = (op == OP_ORI) || (op == OP_LUI);
        is_mem     = (op == OP_LW) || (op == OP_SW);
        is_br      = (op == OP_BEQ);
        is_jmp     = (op == OP_J) || (op == OP_JAL) || is_jr;
        is_illegal = !(is_rtype || is_imm || is_mem || is_br || is_jmp);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM. Define ILL_INSTR_EN to add the ill_instr
// output and a sticky ILL state for undecodable instructions.
module mc_ctrl
    import mips_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int NPCOP_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               irwr,
    output logic               pcwr,
    output logic [NPCOP_W-1:0] npc_op,
    output logic               regwr,
    output logic [1:0]         regdst,
    output logic [1:0]         wdsel,
    output logic               alusrc,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         ext_op,
    output logic               dmwr,
`ifdef ILL_INSTR_EN
    output logic               ill_instr,
`endif
    output logic [3:0]         state_o
);

    state_t     state_reg, state_next;
    logic [5:0] op_reg, funct_reg;
    logic       is_rtype, is_imm, is_mem, is_br, is_jmp, is_illegal;

    mc_ctrl_dec u_dec (
        .op         (op),
        .funct      (funct),
        .is_rtype   (is_rtype),
        .is_imm     (is_imm),
        .is_mem     (is_mem),
        .is_br      (is_br),
        .is_jmp     (is_jmp),
        .is_illegal (is_illegal)
    );

    // op/funct are captured in DCD so later states never depend on IR timing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_FETCH;
            op_reg    <= '0;
            funct_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DCD) begin
                op_reg    <= op;
                funct_reg <= funct;
            end
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH: state_next = S_DCD;
            S_DCD: begin
                if (is_mem)                  state_next = S_MA;
                else if (is_rtype || is_imm) state_next = S_EXE;
                else if (is_br)              state_next = S_BR;
                else if (is_jmp)             state_next = S_JMP;
                else if (is_illegal)
`ifdef ILL_INSTR_EN
                    state_next = S_ILL;
`else
                    state_next = S_FETCH;
`endif
            end
            S_MA:  state_next = (op_reg == OP_LW) ? S_MR : S_MW;
            S_MR:  state_next = S_WBM;
            S_EXE: state_next = S_WBA;
`ifdef ILL_INSTR_EN
            S_ILL: state_next = S_ILL;
`endif
            default: state_next = S_FETCH;
        endcase
    end

    // Moore outputs, gated by rst so nothing is asserted while held in reset
    always_comb begin
        irwr   = 1'b0;
        pcwr   = 1'b0;
        npc_op = NPCOP_W'(NPC_PC4);
        regwr  = 1'b0;
        regdst = RD_RT;
        wdsel  = WD_ALU;
        alusrc = 1'b0;
        alu_op = ALUOP_W'(ALU_ADD);
        ext_op = EXT_ZERO;
        dmwr   = 1'b0;
        if (rst) begin
            case (state_reg)
                S_FETCH: begin
                    irwr = 1'b1;
                    pcwr = 1'b1;
                end
                S_MA, S_MR, S_MW, S_WBM: begin
                    alusrc = 1'b1;
                    ext_op = EXT_SIGN;
                    wdsel  = WD_DM;
                    regwr  = (state_reg == S_WBM);
                    dmwr   = (state_reg == S_MW);
                end
                S_EXE, S_WBA: begin
                    regwr = (state_reg == S_WBA);
                    if (op_reg == OP_RTYPE) begin
                        regdst = RD_RD;
                        alu_op = (funct_reg == FN_SUBU) ? ALUOP_W'(ALU_SUB) : ALUOP_W'(ALU_ADD);
                    end else if (op_reg == OP_ORI) begin
                        alusrc = 1'b1;
                        alu_op = ALUOP_W'(ALU_OR);
                    end else begin
                        alusrc = 1'b1;
                        ext_op = EXT_LUI;
                    end
                end
                S_BR: begin
                    alu_op = ALUOP_W'(ALU_SUB);
                    pcwr   = zero;
                    npc_op = NPCOP_W'(NPC_BR);
                end
                S_JMP: begin
                    pcwr   = 1'b1;
                    npc_op = (op_reg == OP_RTYPE) ? NPCOP_W'(NPC_JR) : NPCOP_W'(NPC_J);
                    if (op_reg == OP_JAL) begin
                        regwr  = 1'b1;
                        regdst = RD_RA;
                        wdsel  = WD_PC;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ILL_INSTR_EN
    assign ill_instr = rst && (state_reg == S_ILL);
`endif
    assign state_o = state_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: walks each instruction class
// state by state against hand-computed output vectors.
module tb_mc_ctrl;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, funct;
    logic       zero;
    logic       irwr, pcwr, regwr, alusrc, dmwr;
    logic [1:0] npc_op, regdst, wdsel, ext_op;
    logic [2:0] alu_op;
    logic [3:0] state_o;
`ifdef ILL_INSTR_EN
    logic       ill_instr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.ALUOP_W(3), .NPCOP_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .irwr      (irwr),
        .pcwr      (pcwr),
        .npc_op    (npc_op),
        .regwr     (regwr),
        .regdst    (regdst),
        .wdsel     (wdsel),
        .alusrc    (alusrc),
        .alu_op    (alu_op),
        .ext_op    (ext_op),
        .dmwr      (dmwr),
`ifdef ILL_INSTR_EN
        .ill_instr (ill_instr),
`endif
        .state_o   (state_o)
    );

    logic [15:0] outv;
    assign outv = {irwr, pcwr, npc_op, regwr, regdst, wdsel, alusrc, alu_op, ext_op, dmwr};

    function automatic logic [15:0] ov(input logic ir, input logic pc, input logic [1:0] npc,
                                       input logic rw, input logic [1:0] rd, input logic [1:0] wd,
                                       input logic as, input logic [2:0] alu, input logic [1:0] ext,
                                       input logic dw);
        return {ir, pc, npc, rw, rd, wd, as, alu, ext, dw};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check one cycle (state and packed outputs) then advance to the next negedge
    task automatic ec(input string tag, input logic [3:0] st, input logic [15:0] v);
        check({tag, "_st"}, {28'd0, state_o}, {28'd0, st});
        check({tag, "_out"}, {16'd0, outv}, {16'd0, v});
        @(negedge clk);
    endtask

    task automatic start(input logic [5:0] o, input logic [5:0] f, input logic z);
        op = o; funct = f; zero = z;
    endtask

    logic [15:0] V_FETCH, V_NONE;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        V_FETCH = ov(1, 1, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 0);
        V_NONE  = '0;
        rst = 1'b0;
        start(6'h00, FN_ADDU, 1'b0);

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_out", {16'd0, outv}, 32'd0);
            check("rst_st", {28'd0, state_o}, 32'd0);
        end
        rst = 1'b1;
        #1;
        check("rel_irwr_pcwr", {30'd0, irwr, pcwr}, 32'd3);

        // addu
        ec("addu_f", S_FETCH, V_FETCH);
        ec("addu_d", S_DCD, V_NONE);
        ec("addu_e", S_EXE, ov(0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 3'b000, 2'b00, 0));
        ec("addu_w", S_WBA, ov(0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 3'b000, 2'b00, 0));
        check("addu_len", {28'd0, state_o}, S_FETCH);

        // subu
        start(6'h00, FN_SUBU, 1'b0);
        ec("subu_f", S_FETCH, V_FETCH);
        ec("subu_d", S_DCD, V_NONE);
        ec("subu_e", S_EXE, ov(0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 3'b001, 2'b00, 0));
        ec("subu_w", S_WBA, ov(0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 3'b001, 2'b00, 0));

        // ori
        start(OP_ORI, 6'h15, 1'b0);
        ec("ori_f", S_FETCH, V_FETCH);
        ec("ori_d", S_DCD, V_NONE);
        ec("ori_e", S_EXE, ov(0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b010, 2'b00, 0));
        ec("ori_w", S_WBA, ov(0, 0, 2'b00, 1, 2'b00, 2'b00, 1, 3'b010, 2'b00, 0));

        // lui
        start(OP_LUI, 6'h00, 1'b0);
        ec("lui_f", S_FETCH, V_FETCH);
        ec("lui_d", S_DCD, V_NONE);
        ec("lui_e", S_EXE, ov(0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b000, 2'b10, 0));
        ec("lui_w", S_WBA, ov(0, 0, 2'b00, 1, 2'b00, 2'b00, 1, 3'b000, 2'b10, 0));

        // lw: five cycles
        start(OP_LW, 6'h04, 1'b0);
        ec("lw_f", S_FETCH, V_FETCH);
        ec("lw_d", S_DCD, V_NONE);
        ec("lw_ma", S_MA, ov(0, 0, 2'b00, 0, 2'b00, 2'b01, 1, 3'b000, 2'b01, 0));
        ec("lw_mr", S_MR, ov(0, 0, 2'b00, 0, 2'b00, 2'b01, 1, 3'b000, 2'b01, 0));
        ec("lw_wbm", S_WBM, ov(0, 0, 2'b00, 1, 2'b00, 2'b01, 1, 3'b000, 2'b01, 0));
        check("lw_len", {28'd0, state_o}, S_FETCH);

        // sw: dmwr for exactly one cycle
        start(OP_SW, 6'h08, 1'b0);
        ec("sw_f", S_FETCH, V_FETCH);
        ec("sw_d", S_DCD, V_NONE);
        ec("sw_ma", S_MA, ov(0, 0, 2'b00, 0, 2'b00, 2'b01, 1, 3'b000, 2'b01, 0));
        ec("sw_mw", S_MW, ov(0, 0, 2'b00, 0, 2'b00, 2'b01, 1, 3'b000, 2'b01, 1));
        check("sw_len", {28'd0, state_o}, S_FETCH);

        // beq taken / not taken
        start(OP_BEQ, 6'h02, 1'b1);
        ec("beq1_f", S_FETCH, V_FETCH);
        ec("beq1_d", S_DCD, V_NONE);
        ec("beq1_br", S_BR, ov(0, 1, 2'b01, 0, 2'b00, 2'b00, 0, 3'b001, 2'b00, 0));
        start(OP_BEQ, 6'h02, 1'b0);
        ec("beq0_f", S_FETCH, V_FETCH);
        ec("beq0_d", S_DCD, V_NONE);
        ec("beq0_br", S_BR, ov(0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 3'b001, 2'b00, 0));
        check("beq0_len", {28'd0, state_o}, S_FETCH);

        // j, jal, jr
        start(OP_J, 6'h11, 1'b0);
        ec("j_f", S_FETCH, V_FETCH);
        ec("j_d", S_DCD, V_NONE);
        ec("j_jmp", S_JMP, ov(0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 0));
        start(OP_JAL, 6'h11, 1'b0);
        ec("jal_f", S_FETCH, V_FETCH);
        ec("jal_d", S_DCD, V_NONE);
        ec("jal_jmp", S_JMP, ov(0, 1, 2'b10, 1, 2'b10, 2'b10, 0, 3'b000, 2'b00, 0));
        start(6'h00, FN_JR, 1'b0);
        ec("jr_f", S_FETCH, V_FETCH);
        ec("jr_d", S_DCD, V_NONE);
        ec("jr_jmp", S_JMP, ov(0, 1, 2'b11, 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 0));
        check("jr_len", {28'd0, state_o}, S_FETCH);

        // Reset pulsed during MR of lw: no writeback, back to FETCH
        start(OP_LW, 6'h00, 1'b0);
        ec("lwr_f", S_FETCH, V_FETCH);
        ec("lwr_d", S_DCD, V_NONE);
        ec("lwr_ma", S_MA, ov(0, 0, 2'b00, 0, 2'b00, 2'b01, 1, 3'b000, 2'b01, 0));
        check("lwr_mr_st", {28'd0, state_o}, S_MR);
        rst = 1'b0;
        #1;
        check("lwr_rst_st", {28'd0, state_o}, S_FETCH);
        check("lwr_rst_out", {16'd0, outv}, 32'd0);
        @(negedge clk);
        check("lwr_hold_regwr", {31'd0, regwr}, 32'd0);
        check("lwr_hold_st", {28'd0, state_o}, S_FETCH);
        start(OP_SW, 6'h00, 1'b0);
        rst = 1'b1;
        #1;
        ec("rel_sw_f", S_FETCH, V_FETCH);
        ec("rel_sw_d", S_DCD, V_NONE);
        ec("rel_sw_ma", S_MA, ov(0, 0, 2'b00, 0, 2'b00, 2'b01, 1, 3'b000, 2'b01, 0));
        ec("rel_sw_mw", S_MW, ov(0, 0, 2'b00, 0, 2'b00, 2'b01, 1, 3'b000, 2'b01, 1));

        // Unknown opcode
        start(6'h3F, 6'h00, 1'b0);
        ec("unk_f", S_FETCH, V_FETCH);
`ifdef ILL_INSTR_EN
        ec("unk_d", S_DCD, V_NONE);
        for (int i = 0; i < 3; i++) begin
            check("ill_st", {28'd0, state_o}, S_ILL);
            check("ill_flag", {31'd0, ill_instr}, 32'd1);
            check("ill_out", {16'd0, outv}, 32'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check("ill_rst_flag", {31'd0, ill_instr}, 32'd0);
        check("ill_rst_st", {28'd0, state_o}, S_FETCH);
        @(negedge clk);
        rst = 1'b1;
        #1;
`else
        ec("unk_d", S_DCD, V_NONE);
        check("unk_len", {28'd0, state_o}, S_FETCH);
        start(6'h00, 6'h20, 1'b0);
        ec("unkf_f", S_FETCH, V_FETCH);
        ec("unkf_d", S_DCD, V_NONE);
`endif
        check("end_st", {28'd0, state_o}, S_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control FSM.
- Sequences the instruction register write, PC update, register file, ALU, extender and data memory for one instruction at a time.
- Sits beside the datapath:
  - Consumes opcode/funct fields from the instruction register output and the ALU zero flag.
  - Drives every write enable and mux select, including irwr into the instruction register.

Parameters:
ALUOP_W, 3, width of alu_op (000 add, 001 sub, 010 or)
NPCOP_W, 2, width of npc_op (00 PC+4, 01 branch PC+4+(sext(imm16)<<2), 10 {PC[31:28],imm26,2'b00}, 11 GPR[rs])

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU result==0
irwr  out  1  instruction register write enable
pcwr  out  1  PC write enable
npc_op  out  NPCOP_W  next-PC source select
regwr  out  1  register file write enable
regdst  out  2  write address: 00 rt, 01 rd, 10 $31
wdsel  out  2  write data: 00 ALU, 01 DM, 10 PC
alusrc  out  1  0 GPR[rt], 1 extended imm
alu_op  out  ALUOP_W  ALU function
ext_op  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16
dmwr  out  1  data memory write enable
state_o  out  4  current state encoding, for debug

Behaviour:
- Supported instructions:
  - R-type (op=000000) with funct addu=100001, subu=100011, jr=001000.
  - ori=001101, lui=001111, lw=100011, sw=101011, beq=000100, j=000010, jal=000011.
- States: FETCH, DCD, MA, MR, MW, WBM, EXE, WBA, BR, JMP.
- Reset: while rst=0, state=FETCH and all outputs are forced to 0, including irwr and pcwr. Release is asynchronous to state but takes effect at the first clk edge.
- Outputs are Moore (decode of state plus latched op/funct). alu_op, alusrc, ext_op, regdst and wdsel hold their values across dependent states.
- FETCH:
  - Outputs: irwr=1, pcwr=1, npc_op=00.
  - Next state: DCD.
- DCD:
  - Reads registers; no enables asserted.
  - Next state: lw/sw -> MA; R-type addu/subu, ori, lui -> EXE; beq -> BR; j, jal, jr -> JMP; anything else -> FETCH (NOP).
- MA:
  - Outputs: alusrc=1, ext_op=01, alu_op=add.
  - Next state: lw -> MR; sw -> MW.
- MR: next state WBM.
- MW:
  - Outputs: dmwr=1 (one cycle exactly).
  - Next state: FETCH.
- WBM:
  - Outputs: regwr=1, regdst=00, wdsel=01.
  - Next state: FETCH.
- EXE:
  - addu -> alu_op=add, alusrc=0.
  - subu -> alu_op=sub, alusrc=0.
  - ori -> alu_op=or, alusrc=1, ext_op=00.
  - lui -> alu_op=add, alusrc=1, ext_op=10.
  - Next state: WBA.
- WBA:
  - Outputs: regwr=1, regdst = 01 for R-type else 00, wdsel=00.
  - Next state: FETCH.
- BR:
  - Outputs: alu_op=sub, alusrc=0; pcwr=zero; npc_op=01.
  - Next state: FETCH.
- JMP:
  - pcwr=1; npc_op = 10 for j/jal, 11 for jr.
  - jal also asserts regwr=1, regdst=10, wdsel=10. PC already holds PC+4 from FETCH, so $31 receives the return address.
  - Next state: FETCH.
- Cycle counts (FETCH to next FETCH):
  - R/ori/lui: 4.
  - lw: 5.
  - sw: 4.
  - beq, j, jal, jr: 3.
  - Unknown: 2.
- Invariants:
  - irwr is asserted only in FETCH.
  - Never more than one of regwr/dmwr per cycle.
  - pcwr is asserted only in FETCH, BR and JMP.
- Reset mid-instruction: FSM returns to FETCH at once and no partial writeback occurs. The first FETCH after release is a full fetch.
- Invalid state encoding: next state is FETCH.

Optional Feature:
ILL_INSTR_EN.
- When defined: adds output ill_instr (1 bit). An unknown op or funct in DCD moves the FSM to a sticky ILL state:
  - ill_instr=1 and all enables are 0.
  - ILL is left only by reset.
- When not defined: there is no port, and unknown encodings go DCD -> FETCH as a NOP.

Decomposition:
- Shared package mips_pkg:
  - Opcode and funct localparams.
  - State encoding.
  - npc_op, alu_op, ext_op, regdst and wdsel encodings.
- One sub-module is natural: mc_ctrl_dec, a combinational instruction class decoder (is_rtype, is_mem, is_br, is_jmp, is_illegal) used by the DCD transitions.

Test Plan:
- Reset: hold rst=0 three cycles -> all outputs 0, state_o=FETCH; release -> irwr=pcwr=1 on the first edge.
- addu (op=0, funct=0x21) -> sequence FETCH, DCD, EXE, WBA; regwr=1 with regdst=01 only in WBA; 4 cycles.
- lw (op=0x23) -> 5 cycles, regwr=1 with wdsel=01 in WBM. sw (op=0x2B) -> dmwr high exactly 1 cycle, regwr never asserted.
- beq with zero=1 -> pcwr=1, npc_op=01 in BR. With zero=0 -> pcwr=0 and FSM returns to FETCH after 3 cycles.
- jal (op=0x03) -> JMP asserts pcwr=1, npc_op=10, regwr=1, regdst=10, wdsel=10. jr (op=0, funct=0x08) -> npc_op=11, regwr=0.
- rst pulsed low during MR of lw -> regwr is never asserted and state returns to FETCH. With ILL_INSTR_EN defined, op=0x3F -> ill_instr=1, which holds until reset.
